// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 16-bit BreadBoard ALU: buffers (opcode, operand) commands,
// issues them one at a time, and returns each captured result on a valid/ready channel.
module alu_cmd_sequencer #(
  parameter int         DEPTH   = 4,
  parameter int         ALU_LAT = 1,
  parameter logic [3:0] HOLD_OP = 4'hE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [3:0]              cmd_op,
  input  logic [15:0]             cmd_operand,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [3:0]              rsp_op,
  output logic [31:0]             rsp_data,
  output logic [1:0]              rsp_err,
  output logic [3:0]              alu_op,
  output logic [15:0]             alu_operand,
  input  logic [31:0]             alu_result,
  input  logic [1:0]              alu_err,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [AW:0]   FULL_COUNT = DEPTH[AW:0];
  localparam logic [CW-1:0] LAST_CYCLE = CW'(ALU_LAT - 1);
  localparam logic [3:0]    ILLEGAL_OP = 4'hF;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e        state_q;
  logic [19:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;
  logic [19:0]   head;
  logic [CW-1:0] cnt_q;
  logic          rsp_valid_q;
  logic [3:0]    rsp_op_q, alu_op_q;
  logic [31:0]   rsp_data_q;
  logic [1:0]    rsp_err_q;
  logic [15:0]   alu_operand_q;

  // Readiness comes only from the registered count, so a same-cycle pop never raises it.
  assign cmd_ready   = (count_q != FULL_COUNT);
  assign head        = mem_q[rd_ptr_q];
  assign busy        = (state_q != IDLE) || (count_q != '0);
  assign fifo_count  = count_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_op      = rsp_op_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign alu_op      = alu_op_q;
  assign alu_operand = alu_operand_q;

  always_comb begin
    push     = cmd_valid && cmd_ready;
    pop      = (state_q == IDLE) && (count_q != '0);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_operand};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // alu_op_q/alu_operand_q double as the issue register; illegal opcodes bypass the ALU.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_op_q      <= 4'h0;
      rsp_data_q    <= 32'h0;
      rsp_err_q     <= 2'b00;
      alu_op_q      <= HOLD_OP;
      alu_operand_q <= 16'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            if (head[19:16] == ILLEGAL_OP) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= 32'h0;
              rsp_err_q   <= 2'b11;
              rsp_op_q    <= ILLEGAL_OP;
            end else begin
              state_q       <= ISSUE;
              cnt_q         <= '0;
              alu_op_q      <= head[19:16];
              alu_operand_q <= head[15:0];
            end
          end
        end
        ISSUE: begin
          if (cnt_q == LAST_CYCLE) begin
            state_q       <= RESP;
            rsp_valid_q   <= 1'b1;
            rsp_data_q    <= alu_result;
            rsp_err_q     <= alu_err;
            rsp_op_q      <= alu_op_q;
            alu_op_q      <= HOLD_OP;
            alu_operand_q <= 16'h0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
